// File: rtl/snn_aer_pkg.sv
// Shared types and helpers for the spike address-event receive path.
package snn_aer_pkg;

    localparam int DEF_N_NEURONS = 16;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [0:0] {
        ACCUM   = 1'b0,
        PENDING = 1'b1
    } aer_state_e;

    // Saturating increment for a counter that is w bits wide.
    // Callers widen their counter to 32 bits and narrow the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/aer_spike_decoder_if.sv
// Event input, timestep output slot and error flags of the AER decoder.
interface aer_spike_decoder_if
    import snn_aer_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W
);
    logic                 ev_valid;
    logic [ADDR_W-1:0]    ev_addr;
    logic                 ev_ready;
    logic                 tick;
    logic                 spk_valid;
    logic                 spk_ready;
    logic [N_NEURONS-1:0] spk_vec;
    logic [CNT_W-1:0]     spk_cnt;
    logic                 err_clr;
    logic                 err_overrun;
    logic                 err_addr;

    // Upstream encoder / control side.
    modport master (
        output ev_valid, ev_addr, tick, spk_ready, err_clr,
        input  ev_ready, spk_valid, spk_vec, spk_cnt, err_overrun, err_addr
    );

    // Decoder side.
    modport slave (
        input  ev_valid, ev_addr, tick, spk_ready, err_clr,
        output ev_ready, spk_valid, spk_vec, spk_cnt, err_overrun, err_addr
    );
endinterface

// File: rtl/spike_addr_decoder.sv
// Combinational neuron index -> one-hot decoder with range flag.
module spike_addr_decoder #(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic [N_NEURONS-1:0] onehot,
    output logic                 in_range
);

    // Out-of-range indices decode to all zeros.
    always_comb begin
        onehot   = '0;
        in_range = (32'(addr) < 32'(N_NEURONS));
        for (int i = 0; i < N_NEURONS; i++) begin
            if (32'(addr) == 32'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/aer_spike_decoder.sv
// AER receive end: accumulates decoded spike events per timestep and hands the
// closed timestep to the downstream array through a one-entry valid/ready slot.
module aer_spike_decoder
    import snn_aer_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int ADDR_W    = $clog2(N_NEURONS),
    parameter int CNT_W     = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    aer_spike_decoder_if.slave  bus
);

    aer_state_e           state, state_nx;
    logic                 live;
    logic [N_NEURONS-1:0] acc, acc_upd, dec_onehot;
    logic [CNT_W-1:0]     acc_cnt, cnt_upd;
    logic                 in_range;
    logic                 slot_valid;
    logic [N_NEURONS-1:0] slot_vec;
    logic [CNT_W-1:0]     slot_cnt;
    logic                 ev_ready, fire, slot_free, xfer;
    logic                 ovr_set, addr_set;
    logic                 err_ovr_q, err_addr_q;

    spike_addr_decoder #(
        .N_NEURONS (N_NEURONS),
        .ADDR_W    (ADDR_W)
    ) u_dec (
        .addr     (bus.ev_addr),
        .onehot   (dec_onehot),
        .in_range (in_range)
    );

    // An event in the same cycle as the closing tick is folded into acc_upd,
    // so it lands in the transferred timestep rather than the next one.
    assign fire      = bus.ev_valid & ev_ready;
    assign slot_free = ~slot_valid | bus.spk_ready;
    assign addr_set  = fire & ~in_range;
    assign acc_upd   = acc | ((fire && in_range) ? dec_onehot : '0);
    assign cnt_upd   = fire ? CNT_W'(sat_inc(32'(acc_cnt), CNT_W)) : acc_cnt;

    // Next state, backpressure and transfer strobe.
    always_comb begin
        state_nx = state;
        ev_ready = 1'b0;
        xfer     = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            ACCUM: begin
                ev_ready = live;
                if (bus.tick) begin
                    if (slot_free) xfer     = 1'b1;
                    else           state_nx = PENDING;
                end
            end
            PENDING: begin
                // Accumulator is frozen; a further tick is dropped and flagged.
                ovr_set = bus.tick;
                if (slot_free) begin
                    xfer     = 1'b1;
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    // State register; live holds ev_ready low until the cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    // Per-timestep accumulator; cleared when its contents move to the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (xfer) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            acc     <= acc_upd;
            acc_cnt <= cnt_upd;
        end
    end

    // Output slot: reload on transfer, otherwise hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_vec   <= '0;
            slot_cnt   <= '0;
        end else if (xfer) begin
            slot_valid <= 1'b1;
            slot_vec   <= acc_upd;
            slot_cnt   <= cnt_upd;
        end else if (bus.spk_ready) begin
            slot_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovr_q  <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            if (ovr_set)          err_ovr_q  <= 1'b1;
            else if (bus.err_clr) err_ovr_q  <= 1'b0;
            if (addr_set)         err_addr_q <= 1'b1;
            else if (bus.err_clr) err_addr_q <= 1'b0;
        end
    end

    assign bus.ev_ready    = ev_ready;
    assign bus.spk_valid   = slot_valid;
    assign bus.spk_vec     = slot_vec;
    assign bus.spk_cnt     = slot_cnt;
    assign bus.err_overrun = err_ovr_q;
    assign bus.err_addr    = err_addr_q;

endmodule

// File: tb/tb_aer_spike_decoder.sv
// Directed bench: three decoder instances (16/8, 12/8, 16/2) share one stimulus.
module tb_aer_spike_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic [3:0] ev_addr = 4'd0;
    logic       tick = 1'b0;
    logic       spk_ready = 1'b0;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    aer_spike_decoder_if #(.N_NEURONS(16), .ADDR_W(4), .CNT_W(8)) bus16 ();
    aer_spike_decoder_if #(.N_NEURONS(12), .ADDR_W(4), .CNT_W(8)) bus12 ();
    aer_spike_decoder_if #(.N_NEURONS(16), .ADDR_W(4), .CNT_W(2)) bus2  ();

    assign bus16.ev_valid = ev_valid;  assign bus12.ev_valid = ev_valid;  assign bus2.ev_valid = ev_valid;
    assign bus16.ev_addr  = ev_addr;   assign bus12.ev_addr  = ev_addr;   assign bus2.ev_addr  = ev_addr;
    assign bus16.tick     = tick;      assign bus12.tick     = tick;      assign bus2.tick     = tick;
    assign bus16.spk_ready = spk_ready; assign bus12.spk_ready = spk_ready; assign bus2.spk_ready = spk_ready;
    assign bus16.err_clr  = err_clr;   assign bus12.err_clr  = err_clr;   assign bus2.err_clr  = err_clr;

    aer_spike_decoder #(.N_NEURONS(16), .ADDR_W(4), .CNT_W(8)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    aer_spike_decoder #(.N_NEURONS(12), .ADDR_W(4), .CNT_W(8)) dut12 (.clk(clk), .rst(rst), .bus(bus12));
    aer_spike_decoder #(.N_NEURONS(16), .ADDR_W(4), .CNT_W(2)) dut2  (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a);
        ev_valid = 1'b1;
        ev_addr  = a;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_valid", 32'(bus16.spk_valid), 32'h0);
        chk("rst_vec",   32'(bus16.spk_vec),   32'h0);
        chk("rst_cnt",   32'(bus16.spk_cnt),   32'h0);
        chk("rst_ovr",   32'(bus16.err_overrun), 32'h0);
        chk("rst_addr",  32'(bus16.err_addr),  32'h0);
        rst = 1'b0;
        step();
        chk("rdy_after_rst", 32'(bus16.ev_ready), 32'h1);

        // 1: events 3,15,0 -> 8009, cnt 3, one-cycle valid, next timestep empty
        spk_ready = 1'b1;
        send(4'd3); send(4'd15); send(4'd0);
        do_tick();
        chk("t1_valid", 32'(bus16.spk_valid), 32'h1);
        chk("t1_vec",   32'(bus16.spk_vec),   32'h8009);
        chk("t1_cnt",   32'(bus16.spk_cnt),   32'h3);
        step();
        chk("t1_valid_drop", 32'(bus16.spk_valid), 32'h0);
        do_tick();
        chk("t1_next_vec", 32'(bus16.spk_vec), 32'h0);
        chk("t1_next_cnt", 32'(bus16.spk_cnt), 32'h0);
        step();

        // 2: duplicates counted
        send(4'd5); send(4'd5); send(4'd5);
        do_tick();
        chk("t2_vec", 32'(bus16.spk_vec), 32'h0020);
        chk("t2_cnt", 32'(bus16.spk_cnt), 32'h3);
        step();

        // 3: backpressure, pending transfer, overrun
        spk_ready = 1'b0;
        send(4'd1);
        do_tick();
        chk("t3_vec1", 32'(bus16.spk_vec), 32'h0002);
        send(4'd2);
        do_tick();
        chk("t3_pend_rdy",  32'(bus16.ev_ready), 32'h0);
        chk("t3_hold_vec",  32'(bus16.spk_vec),  32'h0002);
        do_tick();
        chk("t3_overrun",   32'(bus16.err_overrun), 32'h1);
        chk("t3_hold_vec2", 32'(bus16.spk_vec),  32'h0002);
        spk_ready = 1'b1;
        step();
        chk("t3_vec2",   32'(bus16.spk_vec),   32'h0004);
        chk("t3_cnt2",   32'(bus16.spk_cnt),   32'h1);
        chk("t3_valid2", 32'(bus16.spk_valid), 32'h1);
        chk("t3_rdy_back", 32'(bus16.ev_ready), 32'h1);
        step();
        chk("t3_valid_drop", 32'(bus16.spk_valid), 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_ovr_clr", 32'(bus16.err_overrun), 32'h0);

        // 4: event coincident with tick belongs to closing timestep
        ev_valid = 1'b1; ev_addr = 4'd7; tick = 1'b1;
        step();
        ev_valid = 1'b0; tick = 1'b0;
        chk("t4_vec", 32'(bus16.spk_vec), 32'h0080);
        chk("t4_cnt", 32'(bus16.spk_cnt), 32'h1);
        step();
        do_tick();
        chk("t4_next_vec", 32'(bus16.spk_vec), 32'h0);
        step();

        // 5: out-of-range address on 12-neuron instance
        chk("t5_addr_pre", 32'(bus12.err_addr), 32'h0);
        send(4'd13);
        chk("t5_err_addr", 32'(bus12.err_addr), 32'h1);
        do_tick();
        chk("t5_vec12", 32'(bus12.spk_vec), 32'h0);
        chk("t5_cnt12", 32'(bus12.spk_cnt), 32'h1);
        chk("t5_vec16", 32'(bus16.spk_vec), 32'h2000);
        chk("t5_addr16", 32'(bus16.err_addr), 32'h0);
        step();

        // 6: saturating counter, then async reset mid-timestep
        for (int i = 0; i < 5; i++) send(4'd1);
        do_tick();
        chk("t6_cnt2",  32'(bus2.spk_cnt),  32'h3);
        chk("t6_vec2",  32'(bus2.spk_vec),  32'h0002);
        chk("t6_cnt16", 32'(bus16.spk_cnt), 32'h5);
        step();
        send(4'd4); send(4'd6);
        rst = 1'b1;
        #1;
        chk("t6_rst_vec",   32'(bus2.spk_vec),   32'h0);
        chk("t6_rst_cnt",   32'(bus2.spk_cnt),   32'h0);
        chk("t6_rst_valid", 32'(bus2.spk_valid), 32'h0);
        chk("t6_rst_rdy",   32'(bus2.ev_ready),  32'h0);
        chk("t6_rst_eaddr", 32'(bus12.err_addr), 32'h0);
        step();
        rst = 1'b0;
        step(); step();
        chk("t6_rdy_back", 32'(bus2.ev_ready), 32'h1);
        do_tick();
        chk("t6_post_vec", 32'(bus16.spk_vec), 32'h0);
        chk("t6_post_cnt", 32'(bus16.spk_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
